// File: rtl/dmx8_seq.sv
// dmx8_seq: sequential 1-to-8 demultiplexer / deserializer.
// Each accepted bit is written into one of eight slots of q. The slot comes from
// the explicit address s, or from an internal auto-increment pointer. Once all
// eight slots have been written, the byte is held with full=1 until ack.
// The optional registered odd-parity output is built only when DMX8_PARITY_EN is
// defined. Otherwise par is tied low.
module dmx8_seq #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       resetl,
    input  logic       clr,
    input  logic       load,
    input  logic       d,
    input  logic       auto,
    input  logic [2:0] s,
    input  logic       ack,
    output logic [7:0] q,
    output logic [2:0] ptr,
    output logic       full,
    output logic       ovr,
    output logic       par
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [7:0] mask, mask_next;
    logic [7:0] q_next;
    logic [2:0] ptr_next;
    logic       ovr_next;
    logic [2:0] sel;
    logic [7:0] onehot;

    assign sel    = auto ? ptr : s;
    assign onehot = 8'd1 << sel;
    assign full   = (state == FULL);

    // Next-state and datapath decode. Priority is clr > ack > load.
    always_comb begin
        // NOTE: every target gets a default before any branch, so no path can
        // leave it unassigned and infer a latch.
        state_next = state;
        mask_next  = mask;
        q_next     = q;
        ptr_next   = ptr;
        ovr_next   = ovr;

        if (clr) begin
            state_next = FILL;
            mask_next  = 8'h00;
            q_next     = RESET_VAL;
            ptr_next   = 3'd0;
            ovr_next   = 1'b0;
        end else begin
            unique case (state)
                FILL: begin
                    if (load) begin
                        q_next[sel] = d;
                        mask_next   = mask | onehot;
                        if (auto)
                            ptr_next = ptr + 3'd1;
                        if ((mask | onehot) == 8'hFF)
                            state_next = FULL;
                    end
                end
                FULL: begin
                    if (ack) begin
                        // The consumer has taken the byte. A load in the same
                        // cycle is the first bit of the next frame.
                        state_next = FILL;
                        mask_next  = 8'h00;
                        if (load) begin
                            q_next[sel] = d;
                            mask_next   = onehot;
                            if (auto)
                                ptr_next = ptr + 3'd1;
                        end
                    end else if (load) begin
                        // q is frozen, so the bit is dropped and the overrun is flagged.
                        ovr_next = 1'b1;
                    end
                end
                default: state_next = FILL;
            endcase
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state <= FILL;
            mask  <= 8'h00;
            q     <= RESET_VAL;
            ptr   <= 3'd0;
            ovr   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state <= state_next;
            mask  <= mask_next;
            q     <= q_next;
            ptr   <= ptr_next;
            ovr   <= ovr_next;
        end
    end

`ifdef DMX8_PARITY_EN
    // Registered odd parity, computed from q_next so it changes on the same edge as q.
    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl)
            par <= ~^RESET_VAL;
        else
            par <= ~^q_next;
    end
`else
    assign par = 1'b0;
`endif

endmodule

// File: tb/tb_dmx8_seq.sv
// Self-checking bench for dmx8_seq. A behavioural model predicts the outputs
// for every driven cycle and pushes them to a scoreboard queue. Each entry is
// popped and compared after the following rising edge.
module tb_dmx8_seq;

    localparam logic [7:0] RV = 8'h3C;

    logic       clk = 1'b0;
    logic       resetl = 1'b0;
    logic       clr = 1'b0, load = 1'b0, d = 1'b0, auto = 1'b0, ack = 1'b0;
    logic [2:0] s = 3'd0;
    logic [7:0] q;
    logic [2:0] ptr;
    logic       full, ovr, par;

    typedef struct {
        logic [7:0] q;
        logic [2:0] ptr;
        logic       full;
        logic       ovr;
        logic       par;
    } exp_t;

    exp_t sb[$];

    // Model state
    logic [7:0] m_q;
    logic [7:0] m_mask;
    logic [2:0] m_ptr;
    logic       m_full;
    logic       m_ovr;

    int vectors = 0;
    int miscompares = 0;

    dmx8_seq #(.RESET_VAL(RV)) dut (
        .clk(clk), .resetl(resetl), .clr(clr), .load(load), .d(d),
        .auto(auto), .s(s), .ack(ack), .q(q), .ptr(ptr), .full(full),
        .ovr(ovr), .par(par)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_par(input logic [7:0] v);
`ifdef DMX8_PARITY_EN
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(v[i]);
        return (ones % 2) == 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_q = RV; m_mask = 8'h00; m_ptr = 3'd0; m_full = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_write(input logic i_d, input logic i_auto, input logic [2:0] i_s);
        int idx;
        idx = i_auto ? int'(m_ptr) : int'(i_s);
        m_q[idx] = i_d;
        m_mask[idx] = 1'b1;
        if (i_auto) m_ptr = (m_ptr == 3'd7) ? 3'd0 : m_ptr + 3'd1;
    endtask

    // Drive one cycle of stimulus, predict its result, and compare after the edge.
    task automatic step(input logic i_clr, input logic i_load, input logic i_d,
                        input logic i_auto, input logic [2:0] i_s, input logic i_ack);
        exp_t e, o;
        @(negedge clk);
        clr = i_clr; load = i_load; d = i_d; auto = i_auto; s = i_s; ack = i_ack;
        if (i_clr) begin
            model_reset();
        end else if (m_full) begin
            if (i_ack) begin
                m_full = 1'b0;
                m_mask = 8'h00;
                if (i_load) model_write(i_d, i_auto, i_s);
            end else if (i_load) begin
                m_ovr = 1'b1;
            end
        end else if (i_load) begin
            model_write(i_d, i_auto, i_s);
            if (m_mask == 8'hFF) m_full = 1'b1;
        end
        e.q = m_q; e.ptr = m_ptr; e.full = m_full; e.ovr = m_ovr; e.par = exp_par(m_q);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            o = sb.pop_front();
            check("sb_q", {24'd0, q}, {24'd0, o.q});
            check("sb_ptr", {29'd0, ptr}, {29'd0, o.ptr});
            check("sb_full", {31'd0, full}, {31'd0, o.full});
            check("sb_ovr", {31'd0, ovr}, {31'd0, o.ovr});
            check("sb_par", {31'd0, par}, {31'd0, o.par});
        end
        clr = 1'b0; load = 1'b0; ack = 1'b0;
    endtask

    task automatic auto_fill(input logic [7:0] bits);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, bits[i], 1'b1, 3'd0, 1'b0);
    endtask

    initial begin
        logic [7:0] f1;
        model_reset();
        // Reset state
        #12;
        check("rst_q", {24'd0, q}, {24'd0, RV});
        check("rst_ptr", {29'd0, ptr}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovr", {31'd0, ovr}, 32'd0);
        check("rst_par", {31'd0, par}, {31'd0, exp_par(RV)});
        resetl = 1'b1;

        // Auto fill d=1,0,1,1,0,0,1,0 -> 8'h4D
        f1 = 8'b0100_1101;
        auto_fill(f1);
        check("auto_q", {24'd0, q}, 32'h4D);
        check("auto_full", {31'd0, full}, 32'd1);
        check("auto_ptr", {29'd0, ptr}, 32'd0);
`ifdef DMX8_PARITY_EN
        check("par_4D", {31'd0, par}, 32'd1);
`else
        check("par_off", {31'd0, par}, 32'd0);
`endif

        // Overrun, then ack keeps ovr, then clr clears it
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        check("ovr_set", {31'd0, ovr}, 32'd1);
        check("ovr_q_frozen", {24'd0, q}, 32'h4D);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
        check("ack_full", {31'd0, full}, 32'd0);
        check("ovr_sticky", {31'd0, ovr}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);   // ack while not full: ignored
        step(1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);   // clr beats load
        check("clr_ovr", {31'd0, ovr}, 32'd0);
        check("clr_q", {24'd0, q}, {24'd0, RV});

        // Addressed fill s=7..0, d=1 only at slot 3
        for (int i = 7; i >= 0; i--) step(1'b0, 1'b1, (i == 3), 1'b0, 3'(i), 1'b0);
        check("addr_q", {24'd0, q}, 32'h08);
        check("addr_full", {31'd0, full}, 32'd1);
        check("addr_ptr", {29'd0, ptr}, 32'd0);

        // Ack together with load starts a new frame
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
        check("ackld_full", {31'd0, full}, 32'd0);
        check("ackld_q0", {31'd0, q[0]}, 32'd1);
        check("ackld_ptr", {29'd0, ptr}, 32'd1);
        check("ackld_ovr", {31'd0, ovr}, 32'd0);

        // Rewriting slots 0 and 1 does not complete the frame; clr beats ack
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        for (int i = 2; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'(i), 1'b0);
        check("rewrite_not_full", {31'd0, full}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

        // Parity fills 8'h0F then 8'h07, plus a random-bits fill
        auto_fill(8'h0F);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        auto_fill(8'h07);
        check("fill07_q", {24'd0, q}, 32'h07);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 12; i++)
            step(1'b0, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom_range(0, 1));

        // Asynchronous reset mid-fill, checked before any further clock edge
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        #2;
        resetl = 1'b0;
        #1;
        check("arst_q", {24'd0, q}, {24'd0, RV});
        check("arst_ptr", {29'd0, ptr}, 32'd0);
        check("arst_full", {31'd0, full}, 32'd0);
        model_reset();
        #1;
        resetl = 1'b1;
        auto_fill(8'hA6);
        check("post_arst_q", {24'd0, q}, 32'hA6);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
